// File: rtl/mvm_pkg.sv
// Shared types and width/offset helpers for the matrix-vector multiply stage.
// Combinational helpers only, no latency.
// No flow control here; the core and bench use these for slicing packed words.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Packed input word width: all K elements above all x elements.
    function automatic int calc_w_in(input int rows, input int cols, input int wk, input int wx);
        return rows * cols * wk + cols * wx;
    endfunction

    // Result width: full product plus growth for summing cols products.
    function automatic int calc_w_y(input int wk, input int wx, input int cols);
        return wk + wx + $clog2(cols);
    endfunction

    // Bit offset of x[c] inside the packed input word.
    function automatic int x_off(input int c, input int wx);
        return c * wx;
    endfunction

    // Bit offset of K[r][c] inside the packed input word.
    function automatic int k_off(input int r, input int c, input int cols, input int wk, input int wx);
        return cols * wx + (r * cols + c) * wk;
    endfunction

endpackage

// File: rtl/mvm_mac.sv
// Signed multiply-add: acc_out = acc_in + k_el * x_el, full precision.
// Purely combinational, zero latency.
// No flow control; the caller time-multiplexes one instance across all MACs.
module mvm_mac #(
    parameter int W_K = 4,
    parameter int W_X = 4,
    parameter int W_Y = 9
) (
    input  logic signed [W_K-1:0] k_el,
    input  logic signed [W_X-1:0] x_el,
    input  logic signed [W_Y-1:0] acc_in,
    output logic signed [W_Y-1:0] acc_out
);

    localparam int W_P = W_K + W_X;

    logic signed [W_P-1:0] k_ext;
    logic signed [W_P-1:0] x_ext;
    logic signed [W_P-1:0] prod;

    // Widen both operands first so the product is computed at full precision.
    assign k_ext   = W_P'(k_el);
    assign x_ext   = W_P'(x_el);
    assign prod    = k_ext * x_ext;
    assign acc_out = acc_in + W_Y'(prod);

endmodule

// File: rtl/uart_mvm_core.sv
// Computes y = K*x from one packed word, one MAC per cycle, R results out together.
// m_valid rises R*C edges after the accepting edge; next word accepted after the handshake.
// Input cannot stall the source: words arriving outside IDLE are dropped and flag overflow.
module uart_mvm_core
    import mvm_pkg::*;
#(
    parameter int R   = 2,
    parameter int C   = 2,
    parameter int W_K = 4,
    parameter int W_X = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    input  logic [calc_w_in(R, C, W_K, W_X)-1:0]   s_data,
    output logic                                   s_ready,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [R*calc_w_y(W_K, W_X, C)-1:0]     m_data,
    output logic                                   overflow
);

    localparam int W_IN = calc_w_in(R, C, W_K, W_X);
    localparam int W_Y  = calc_w_y(W_K, W_X, C);
    localparam int RW   = (R > 1) ? $clog2(R) : 1;
    localparam int CW   = (C > 1) ? $clog2(C) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(R - 1);
    localparam logic [CW-1:0] C_LAST = CW'(C - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [W_IN-1:0]        op_q;
    logic [RW-1:0]          r_idx;
    logic [CW-1:0]          c_idx;
    logic signed [W_Y-1:0]  acc_q [R];
    logic signed [W_Y-1:0]  mac_sum;
    logic                   last_mac;

    logic signed [W_K-1:0]  k_arr [R][C];
    logic signed [W_X-1:0]  x_arr [C];

    // Unpack the latched operand word into element views.
    for (genvar gc = 0; gc < C; gc++) begin : g_x
        assign x_arr[gc] = op_q[x_off(gc, W_X) +: W_X];
        for (genvar gr = 0; gr < R; gr++) begin : g_k
            assign k_arr[gr][gc] = op_q[k_off(gr, gc, C, W_K, W_X) +: W_K];
        end
    end

    mvm_mac #(
        .W_K (W_K),
        .W_X (W_X),
        .W_Y (W_Y)
    ) u_mac (
        .k_el    (k_arr[r_idx][c_idx]),
        .x_el    (x_arr[c_idx]),
        .acc_in  (acc_q[r_idx]),
        .acc_out (mac_sum)
    );

    assign last_mac = (r_idx == R_LAST) && (c_idx == C_LAST);
    assign s_ready  = (state_q == IDLE);
    assign m_valid  = (state_q == OUT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, leave CALC after the last MAC, leave OUT on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_valid)  state_d = CALC;
            CALC:    if (last_mac) state_d = OUT;
            OUT:     if (m_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand latch, MAC sequencing, result capture and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            r_idx    <= '0;
            c_idx    <= '0;
            m_data   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < R; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (s_valid && (state_q != IDLE)) begin
                overflow <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        op_q  <= s_data;
                        r_idx <= '0;
                        c_idx <= '0;
                        for (int i = 0; i < R; i++) begin
                            acc_q[i] <= '0;
                        end
                    end
                end
                CALC: begin
                    acc_q[r_idx] <= mac_sum;
                    if (c_idx == C_LAST) begin
                        c_idx <= '0;
                        r_idx <= r_idx + RW'(1);
                    end else begin
                        c_idx <= c_idx + CW'(1);
                    end
                    // The last row's sum is still in flight on the MAC output.
                    if (last_mac) begin
                        for (int i = 0; i < R; i++) begin
                            m_data[i*W_Y +: W_Y] <= (i == R - 1) ? mac_sum : acc_q[i];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/uart_mvm_core.md
Name: uart_mvm_core

Overview:
Matrix-vector multiply stage directly downstream of the UART receiver. It takes one packed word per transaction, holding an R x C signed weight matrix K and a C-element signed vector x. It computes y = K*x with one multiply-accumulate per cycle. The R results are presented on a valid/ready output toward the UART transmit path.

Parameters:
R, 2, matrix rows / output elements
C, 2, matrix columns / input vector elements
W_K, 4, signed bit width of each K element
W_X, 4, signed bit width of each x element
(derived localparams) W_IN = R*C*W_K + C*W_X (24 at defaults); W_Y = W_K + W_X + $clog2(C) (9 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  one-cycle pulse: s_data holds a complete packed word
s_data  in  W_IN  packed K and x (layout below)
s_ready  out  1  high only in IDLE; informational, the source does not stall
m_valid  out  1  result available
m_ready  in  1  downstream accepts result
m_data  out  R*W_Y  packed y vector
overflow  out  1  sticky: an input word was dropped

Behaviour:
- Clocking and reset: single clock domain, reset is synchronous and active-high, all flops on posedge clk.
- Reset values: state=IDLE, m_valid=0, m_data=0, overflow=0, counters=0, accumulators=0.
- Input packing (LSB-first, matches the order the UART shifts bits in):
  - x[c] = s_data[c*W_X +: W_X]
  - K[r][c] = s_data[C*W_X + (r*C+c)*W_K +: W_K]
  - All elements are two's complement.
- Output packing: y[r] = m_data[r*W_Y +: W_Y], signed, full precision. W_Y is sized so no overflow is possible.
- FSM states: IDLE, CALC, OUT.
  - IDLE: on s_valid, latch s_data into an operand register, clear all R accumulators, set r_idx=c_idx=0, go to CALC.
  - CALC: each cycle, acc[r_idx] += sext(K[r_idx][c_idx]) * sext(x[c_idx]). Index order is c_idx fastest, then r_idx. The MAC count is exactly R*C.
  - CALC exit: on the final MAC edge, load m_data with the completed sums (including the final product), set m_valid=1, go to OUT.
  - OUT: hold m_valid and m_data stable until m_valid && m_ready. On that edge, m_valid<=0 and state goes to IDLE.
- Latency: m_valid rises R*C clock edges after the accepting edge (4 at defaults). A new word can be accepted from the cycle after the output handshake.
- Drop rule: s_valid while state != IDLE is ignored and sets overflow=1. The in-flight computation is unaffected. overflow clears only on rst.
- Simultaneous events:
  - s_valid in the same cycle as the OUT handshake is dropped, because s_ready is low in OUT.
  - s_valid together with rst: rst wins and nothing is latched.
- Reset mid-operation (CALC or OUT): on the next edge return to IDLE with reset values. No partial result is emitted.
- m_ready is ignored outside OUT.

Decomposition:
- Package mvm_pkg holds:
  - state enum (IDLE, CALC, OUT)
  - width helper functions for W_IN and W_Y
  - index functions for K and x slice offsets, shared with the bench
- One sub-module, mvm_mac: registered-free signed multiply-add, W_K x W_X product added to a W_Y accumulator. It is instantiated once because the MAC is time-multiplexed.

Test Plan:
1. Basic: rst, then s_valid with s_data=0x432165 (K=[[1,2],[3,4]], x=[5,6]), m_ready=1 -> m_valid high 4 edges after accept, m_data=0x4E11 (y0=17, y1=39), overflow=0.
2. Signed extreme: s_data=0x888888 (all -8) -> m_data=0x10080 (y0=y1=128). Then s_data=0x777788 (K=7, x=-8) -> m_data=0x32190 (y=-112 each, 0x190).
3. Backpressure and drop: m_ready=0 for 10 cycles after m_valid, with an s_valid pulse in CALC and another in OUT -> m_valid/m_data stable throughout, overflow=1, then exactly one handshake when m_ready=1.
4. Back-to-back: two words, the second s_valid on the cycle after the first handshake -> both accepted, correct results in order, overflow stays 0.
5. Reset mid-CALC: rst at the 2nd CALC cycle -> next cycle state IDLE, m_valid=0, m_data=0, no output. A following word computes correctly.
6. Reset mid-OUT, with rst and s_valid asserted together -> m_valid=0 after the edge, word not latched, overflow=0.
